// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - first-word-fall-through FIFO controller over a 1-cycle-latency dual-port RAM
// Optional almost-full flag: define DPRAM_FIFO_AFULL_EN (adds AFULL_LEVEL parameter and almost_full port).
module dpram_fifo_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
`ifdef DPRAM_FIFO_AFULL_EN
    ,
    parameter int AFULL_LEVEL = (1 << ADDR_W) - 16
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
`ifdef DPRAM_FIFO_AFULL_EN
    output logic              almost_full,
`endif
    output logic [ADDR_W-1:0] ram_a_addr,
    output logic [1:0]        ram_a_sel,
    output logic              ram_a_we,
    output logic              ram_a_ce,
    output logic [DATA_W-1:0] ram_a_write,
    output logic [ADDR_W-1:0] ram_b_addr,
    output logic [1:0]        ram_b_sel,
    output logic              ram_b_we,
    output logic              ram_b_ce,
    input  logic [DATA_W-1:0] ram_b_read
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(1 << ADDR_W);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              head_vld_q, head_vld_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              skid_vld_q, skid_vld_d;

    logic       push;
    logic       pop;
    logic       fetch;
    logic [1:0] stage_cnt;

    always_comb begin
        in_ready  = (ram_cnt_q != DEPTH_CNT);
        push      = in_valid & in_ready & reset_n & ~flush;
        pop       = head_vld_q & out_ready;
        stage_cnt = {1'b0, head_vld_q} + {1'b0, skid_vld_q};
        // Fetch only if the stage can absorb the word after this cycle's pop.
        fetch     = reset_n & ~flush & (ram_cnt_q != '0) &
                    (({1'b0, stage_cnt} + {2'b00, inflight_q}) < ({2'b00, pop} + 3'd2));
    end

    always_comb begin
        ram_a_ce    = push;
        ram_a_we    = push;
        ram_a_sel   = 2'b11;
        ram_a_addr  = wr_ptr_q;
        ram_a_write = in_data;
        ram_b_ce    = fetch;
        ram_b_we    = 1'b0;
        ram_b_sel   = 2'b11;
        ram_b_addr  = rd_ptr_q;
        out_valid   = head_vld_q;
        out_data    = head_q;
        level       = ram_cnt_q + (ADDR_W + 1)'(inflight_q) + (ADDR_W + 1)'(stage_cnt);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d   = rd_ptr_q + ADDR_W'(fetch);
        inflight_d = fetch;
        case ({push, fetch})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        head_d     = head_q;
        head_vld_d = head_vld_q & ~pop;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!head_vld_d && skid_vld_d) begin
            head_d     = skid_q;
            head_vld_d = 1'b1;
            skid_vld_d = 1'b0;
        end
        // RAM data returns one cycle after the fetch; keep order by filling head first.
        if (inflight_q) begin
            if (!head_vld_d) begin
                head_d     = ram_b_read;
                head_vld_d = 1'b1;
            end else begin
                skid_d     = ram_b_read;
                skid_vld_d = 1'b1;
            end
        end

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ram_cnt_d  = '0;
            inflight_d = 1'b0;
            head_d     = '0;
            head_vld_d = 1'b0;
            skid_d     = '0;
            skid_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

`ifdef DPRAM_FIFO_AFULL_EN
    logic            almost_full_q, almost_full_d;
    logic [ADDR_W:0] level_d;

    always_comb begin
        level_d = ram_cnt_d + (ADDR_W + 1)'(inflight_d) +
                  (ADDR_W + 1)'(head_vld_d) + (ADDR_W + 1)'(skid_vld_d);
        almost_full_d = ~flush & (int'(level_d) >= AFULL_LEVEL);
        almost_full   = almost_full_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end
`endif

endmodule
